// File: rtl/layer_sequencer.sv
// Run/valid scheduler for the inference datapath: sequences receive, embedding,
// three mixing passes, dense, compare and send, with watchdog, abort and latency count.
module layer_sequencer #(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             recv_valid,
    input  logic             emb_valid,
    input  logic             mix_valid,
    input  logic             dense_valid,
    input  logic             send_valid,
    output logic             recv_run,
    output logic             emb_run,
    output logic             mix_run,
    output logic             mix_sel_emb,
    output logic [1:0]       mix_stage,
    output logic             dense_run,
    output logic             send_run,
    output logic [3:0]       state,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RECV = 4'd1,
        S_EMB  = 4'd2,
        S_MIX1 = 4'd3,
        S_MIX2 = 4'd4,
        S_MIX3 = 4'd5,
        S_DENS = 4'd6,
        S_COMP = 4'd7,
        S_SEND = 4'd8,
        S_FIN  = 4'd9,
        S_ERR  = 4'd10
    } state_e;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             mix_run_q, mix_run_d;
    logic [1:0]       mix_stage_q, mix_stage_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             stage_valid;
    logic             watched;
    logic             timed_out;
    logic             start_accept;

    function automatic logic is_run(input state_e s);
        return (s >= S_RECV) && (s <= S_SEND);
    endfunction

    // Valid of the stage being waited on; the MIX entry cycle masks a stale valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stage_valid = 1'b0;
        watched     = 1'b1;
        case (state_q)
            S_RECV:                 stage_valid = recv_valid;
            S_EMB:                  stage_valid = emb_valid;
            S_MIX1, S_MIX2, S_MIX3: stage_valid = mix_valid & ~mix_run_q;
            S_DENS:                 stage_valid = dense_valid;
            S_SEND:                 stage_valid = send_valid;
            default:                watched     = 1'b0;
        endcase
    end

    assign timed_out    = TO_EN && watched && !stage_valid && (wd_q == TO_LAST);
    assign start_accept = start && !abort && ((state_q == S_IDLE) || (state_q == S_FIN));

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else if (timed_out) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: if (start)       state_d = S_RECV;
                S_RECV:        if (stage_valid) state_d = S_EMB;
                S_EMB:         if (stage_valid) state_d = S_MIX1;
                S_MIX1:        if (stage_valid) state_d = S_MIX2;
                S_MIX2:        if (stage_valid) state_d = S_MIX3;
                S_MIX3:        if (stage_valid) state_d = S_DENS;
                S_DENS:        if (stage_valid) state_d = S_COMP;
                S_COMP:                         state_d = S_SEND;
                S_SEND:        if (stage_valid) state_d = S_FIN;
                S_ERR:                          state_d = S_ERR;
                default:                        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (watched && !stage_valid && (wd_q != '1)) begin
            wd_d = wd_q + TO_W'(1);
        end

        // Counts the cycles between the RECV entry edge and the FIN entry edge.
        cycles_d = cycles_q;
        if (start_accept) begin
            cycles_d = '0;
        end else if (is_run(state_q) && is_run(state_d) && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end

        mix_run_d = (state_d != state_q) &&
                    ((state_d == S_MIX1) || (state_d == S_MIX2) || (state_d == S_MIX3));
        case (state_d)
            S_MIX1:  mix_stage_d = 2'd1;
            S_MIX2:  mix_stage_d = 2'd2;
            S_MIX3:  mix_stage_d = 2'd3;
            default: mix_stage_d = 2'd0;
        endcase
        busy_d  = is_run(state_d);
        done_d  = (state_d == S_FIN);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wd_q        <= '0;
            cycles_q    <= '0;
            mix_run_q   <= 1'b0;
            mix_stage_q <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wd_q        <= wd_d;
            cycles_q    <= cycles_d;
            mix_run_q   <= mix_run_d;
            mix_stage_q <= mix_stage_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign recv_run    = (state_q == S_RECV);
    assign emb_run     = (state_q == S_EMB);
    assign dense_run   = (state_q == S_DENS);
    assign send_run    = (state_q == S_SEND);
    assign mix_sel_emb = (state_q == S_MIX1);
    assign mix_run     = mix_run_q;
    assign mix_stage   = mix_stage_q;
    assign state       = state_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a cycle-by-cycle vector table plus
// hand-written watchdog, timeout-tie and mid-run reset sequences.
`timescale 1ns/1ps
module tb_layer_sequencer;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 16;
    localparam int unsigned CNT_W   = 32;

    // Input bundle order: {rst_n, start, abort, recv, emb, mix, dense, send}
    localparam logic [7:0] RUN = 8'b1000_0000;
    localparam logic [7:0] ST  = 8'b0100_0000;
    localparam logic [7:0] AB  = 8'b0010_0000;
    localparam logic [7:0] RV  = 8'b0001_0000;
    localparam logic [7:0] EV  = 8'b0000_1000;
    localparam logic [7:0] MV  = 8'b0000_0100;
    localparam logic [7:0] DV  = 8'b0000_0010;
    localparam logic [7:0] SV  = 8'b0000_0001;

    logic             clk = 1'b0;
    logic             rst_n, start, abort;
    logic             recv_valid, emb_valid, mix_valid, dense_valid, send_valid;
    logic             recv_run, emb_run, mix_run, mix_sel_emb, dense_run, send_run;
    logic [1:0]       mix_stage;
    logic [3:0]       state;
    logic             busy, done, error;
    logic [CNT_W-1:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .recv_valid (recv_valid),
        .emb_valid  (emb_valid),
        .mix_valid  (mix_valid),
        .dense_valid(dense_valid),
        .send_valid (send_valid),
        .recv_run   (recv_run),
        .emb_run    (emb_run),
        .mix_run    (mix_run),
        .mix_sel_emb(mix_sel_emb),
        .mix_stage  (mix_stage),
        .dense_run  (dense_run),
        .send_run   (send_run),
        .state      (state),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cycles     (cycles)
    );

    typedef struct {
        logic [7:0] in;
        logic [3:0] st;
        logic       mr;
        int         cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [7:0] i, input int s, input bit m, input int c);
        vec_t r;
        r.in  = i;
        r.st  = 4'(s);
        r.mr  = m;
        r.cyc = c;
        return r;
    endfunction

    // Expected output bundle from the state code and the mix_run pulse.
    function automatic logic [14:0] exp_outs(input logic [3:0] s, input logic mr);
        logic [1:0] stg;
        stg = ((s >= 4'd3) && (s <= 4'd5)) ? 2'(s - 4'd2) : 2'd0;
        return {s, s == 4'd1, s == 4'd2, mr, s == 4'd3, stg, s == 4'd6, s == 4'd8,
                (s >= 4'd1) && (s <= 4'd8), s == 4'd9, s == 4'd10};
    endfunction

    function automatic logic [14:0] act_outs();
        return {state, recv_run, emb_run, mix_run, mix_sel_emb, mix_stage,
                dense_run, send_run, busy, done, error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] i);
        {rst_n, start, abort, recv_valid, emb_valid, mix_valid, dense_valid, send_valid} = i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        // Reset, nominal run, hold in FIN
        vecs.push_back(v(8'h00,     0, 0, 0));
        vecs.push_back(v(RUN,       0, 0, 0));
        vecs.push_back(v(RUN|ST,    1, 0, 0));
        vecs.push_back(v(RUN|RV,    2, 0, 1));
        vecs.push_back(v(RUN|EV,    3, 1, 2));
        vecs.push_back(v(RUN,       3, 0, 3));
        vecs.push_back(v(RUN|MV,    4, 1, 4));
        vecs.push_back(v(RUN,       4, 0, 5));
        vecs.push_back(v(RUN|MV,    5, 1, 6));
        vecs.push_back(v(RUN,       5, 0, 7));
        vecs.push_back(v(RUN|MV,    6, 0, 8));
        vecs.push_back(v(RUN|DV,    7, 0, 9));
        vecs.push_back(v(RUN,       8, 0, 10));
        vecs.push_back(v(RUN|SV,    9, 0, 10));
        vecs.push_back(v(RUN,       9, 0, 10));
        // Restart from FIN, then mix_valid held high through every MIX stage
        vecs.push_back(v(RUN|ST,    1, 0, 0));
        vecs.push_back(v(RUN|RV,    2, 0, 1));
        vecs.push_back(v(RUN|EV|MV, 3, 1, 2));
        vecs.push_back(v(RUN|MV,    3, 0, 3));
        vecs.push_back(v(RUN|MV,    4, 1, 4));
        vecs.push_back(v(RUN|MV,    4, 0, 5));
        vecs.push_back(v(RUN|MV,    5, 1, 6));
        vecs.push_back(v(RUN|MV,    5, 0, 7));
        vecs.push_back(v(RUN|MV,    6, 0, 8));
        vecs.push_back(v(RUN|MV,    6, 0, 9));
        vecs.push_back(v(RUN|DV,    7, 0, 10));
        vecs.push_back(v(RUN,       8, 0, 11));
        vecs.push_back(v(RUN|SV,    9, 0, 11));
        // Abort from FIN, abort+start collision, start ignored mid-run, abort in MIX2
        vecs.push_back(v(RUN|AB,    0, 0, 11));
        vecs.push_back(v(RUN|AB|ST, 0, 0, 11));
        vecs.push_back(v(RUN|ST,    1, 0, 0));
        vecs.push_back(v(RUN|RV,    2, 0, 1));
        vecs.push_back(v(RUN|EV,    3, 1, 2));
        vecs.push_back(v(RUN|ST,    3, 0, 3));
        vecs.push_back(v(RUN|MV,    4, 1, 4));
        vecs.push_back(v(RUN,       4, 0, 5));
        vecs.push_back(v(RUN|AB|MV, 0, 0, 5));
        vecs.push_back(v(RUN,       0, 0, 5));

        drive(8'h00);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            tick();
            check($sformatf("row%0d_outs", i), 32'(act_outs()), 32'(exp_outs(vecs[i].st, vecs[i].mr)));
            check($sformatf("row%0d_cycles", i), cycles, 32'(vecs[i].cyc));
        end

        // Watchdog expiry in EMB: eight counted cycles, then ERR
        drive(RUN|ST); tick();
        drive(RUN|RV); tick();
        check("to_emb_entry", 32'(state), 32'd2);
        drive(RUN);
        for (int k = 0; k < 7; k++) tick();
        check("to_emb_before_expiry", 32'(state), 32'd2);
        tick();
        check("to_err_state", 32'(state), 32'd10);
        check("to_err_flag", 32'(error), 32'd1);
        check("to_err_emb_run", 32'(emb_run), 32'd0);
        check("to_err_busy", 32'(busy), 32'd0);
        check("to_err_cycles", cycles, 32'd8);
        drive(RUN|ST); tick(); tick();
        check("err_ignores_start", 32'(state), 32'd10);
        drive(RUN|AB); tick();
        check("err_abort_state", 32'(state), 32'd0);
        check("err_abort_flag", 32'(error), 32'd0);
        check("err_abort_cycles", cycles, 32'd8);

        // Timeout tie in DENS: valid on the eighth counted cycle wins
        drive(RUN|ST);    tick();
        drive(RUN|RV);    tick();
        drive(RUN|EV|MV); tick();
        drive(RUN|MV);
        for (int k = 0; k < 6; k++) tick();
        check("tie_dens_entry", 32'(state), 32'd6);
        drive(RUN);
        for (int k = 0; k < 7; k++) tick();
        check("tie_dens_wait", 32'(state), 32'd6);
        drive(RUN|DV); tick();
        check("tie_comp", 32'(state), 32'd7);
        drive(RUN); tick();
        check("tie_send", 32'(state), 32'd8);
        check("tie_send_cycles", cycles, 32'd17);

        // Synchronous reset while in SEND
        drive(8'h00); tick();
        check("rst_mid_send_outs", 32'(act_outs()), 32'd0);
        check("rst_mid_send_cycles", cycles, 32'd0);
        drive(RUN); tick();
        check("rst_release_state", 32'(act_outs()), 32'(exp_outs(4'd0, 1'b0)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
